// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, requester ids and widths
// for the instruction/data RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_state_e;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: one RAM-style request/response port
// (strobe, write, line address/data, ack, timeout).
interface ram_arb_if
  import ram_arb_pkg::*;
();

  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] din;
  logic [LINE_W-1:0] dout;
  logic              ack;
  logic              timeout;

  modport master (
    output stb, we, addr, din,
    input  dout, ack, timeout
  );

  modport slave (
    input  stb, we, addr, din,
    output dout, ack, timeout
  );

endinterface

// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter sharing one RAM port between
// instruction fetch and data access, with a per-grant watchdog.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic      clk,
  input  logic      rst,
  ram_arb_if.slave  inst_i,
  ram_arb_if.slave  data_i,
  ram_arb_if.master ram_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_stb;
  logic             gnt_any;
  logic             expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    gnt_stb = 1'b0;
    unique case (state_q)
      GNT_INST: gnt_stb = inst_i.stb;
      GNT_DATA: gnt_stb = data_i.stb;
      default:  gnt_stb = 1'b0;
    endcase
  end

  assign gnt_any = (state_q != IDLE);

  // A real RAM response in the last cycle wins over the watchdog
  assign expire = gnt_any && (cnt_q == CNT_MAX)
               && !ram_o.ack && !ram_o.timeout;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (inst_i.stb &&
            (!data_i.stb || last_q == REQ_DATA)) begin
          state_d = GNT_INST;
          last_d  = REQ_INST;
          cnt_d   = '0;
        end else if (data_i.stb) begin
          state_d = GNT_DATA;
          last_d  = REQ_DATA;
          cnt_d   = '0;
        end
      end
      GNT_INST, GNT_DATA: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (!gnt_stb || ram_o.ack ||
            ram_o.timeout || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_o.stb  = gnt_stb;
  assign ram_o.we   = (state_q == GNT_DATA) && data_i.we;
  assign ram_o.din  = data_i.din;
  assign ram_o.addr = (state_q == GNT_DATA) ? data_i.addr :
                      (state_q == GNT_INST) ? inst_i.addr :
                      '0;

  assign inst_i.dout = ram_o.dout;
  assign data_i.dout = ram_o.dout;

  assign inst_i.ack = (state_q == GNT_INST) && ram_o.ack;
  assign data_i.ack = (state_q == GNT_DATA) && ram_o.ack;

  assign inst_i.timeout = (state_q == GNT_INST)
                       && (ram_o.timeout || expire);
  assign data_i.timeout = (state_q == GNT_DATA)
                       && (ram_o.timeout || expire);

endmodule
